// File: rtl/demux_1_to_4_rr_scheduler.sv
// demux_1_to_4_rr_scheduler
// Flow-controlled 1-to-4 demultiplexer front end. Each input word is steered
// into one of four single-word holding registers. The target channel comes
// either from a round-robin burst scheduler (BURST words per channel, then
// advance) or from an externally fixed select.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   in_valid/in_ready  producer handshake (in_ready is combinational)
//   in_data [W]        input word
//   mode               0 = round-robin burst, 1 = fixed select
//   fixed_sel [2]      target channel when mode=1
//   select_lines [2]   current target channel
//   out_valid [4]      per-channel word-present flags
//   out_ready [4]      per-channel consumer take strobes
//   out_0..out_3 [W]   per-channel data
module demux_1_to_4_rr_scheduler #(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  input  logic         mode,
  input  logic [1:0]   fixed_sel,
  output logic [1:0]   select_lines,
  output logic [3:0]   out_valid,
  input  logic [3:0]   out_ready,
  output logic [W-1:0] out_0,
  output logic [W-1:0] out_1,
  output logic [W-1:0] out_2,
  output logic [W-1:0] out_3
);

  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);

  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [W-1:0]  data_q [4];
  logic [3:0]    valid_q;
  logic          accept;

  assign select_lines = mode ? fixed_sel : ptr;

  // A slot that is draining this cycle can take a new word, giving one word
  // per cycle per channel. Strict ordering: only the target slot matters.
  assign in_ready = ~valid_q[select_lines] | out_ready[select_lines];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 4'b0000;
      for (int i = 0; i < 4; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept && (select_lines == 2'(i))) begin
          data_q[i]  <= in_data;
          valid_q[i] <= 1'b1;
        end else if (valid_q[i] && out_ready[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  // Burst position only advances on accepted words in round-robin mode.
  // Fixed mode parks the pointer and arms a fresh burst for the return.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 2'd0;
      cnt <= '0;
    end else if (mode) begin
      cnt <= '0;
    end else if (accept) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        ptr <= ptr + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign out_valid = valid_q;
  assign out_0     = data_q[0];
  assign out_1     = data_q[1];
  assign out_2     = data_q[2];
  assign out_3     = data_q[3];

endmodule

// File: tb/tb_demux_1_to_4_rr_scheduler.sv
module tb_demux_1_to_4_rr_scheduler;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mode;
  logic [1:0] fixed_sel;
  logic [1:0] select_lines;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [7:0] out_0, out_1, out_2, out_3;

  int total = 0;
  int bad   = 0;

  demux_1_to_4_rr_scheduler #(.W(8), .BURST(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .fixed_sel(fixed_sel),
    .select_lines(select_lines), .out_valid(out_valid), .out_ready(out_ready),
    .out_0(out_0), .out_1(out_1), .out_2(out_2), .out_3(out_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] chan_data(input int c);
    case (c)
      0: return out_0;
      1: return out_1;
      2: return out_2;
      default: return out_3;
    endcase
  endfunction

  // Stimulus only: pushes n words assuming every target slot is free.
  task automatic send_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; mode = 1'b0;
    fixed_sel = 2'd0; out_ready = 4'b0000;
    #1;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_valid got=%b exp=0000", out_valid); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rst_valid_held got=%b exp=0000", out_valid); end
    total++; if ({out_0, out_1, out_2, out_3} !== 32'h0) begin bad++; $display("FAIL rst_data got=%h exp=0", {out_0, out_1, out_2, out_3}); end
    total++; if (select_lines !== 2'd0) begin bad++; $display("FAIL rst_sel got=%0d exp=0", select_lines); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'b1111;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    out_ready = 4'b1111; mode = 1'b0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #1;
      total++; if (select_lines !== 2'(k / 4)) begin bad++; $display("FAIL rr_sel word=%0d got=%0d exp=%0d", k, select_lines, k / 4); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rr_ready word=%0d got=%b exp=1", k, in_ready); end
      @(posedge clk); #1;
      total++; if (out_valid !== (4'b0001 << (k / 4))) begin bad++; $display("FAIL rr_valid word=%0d got=%b exp=%b", k, out_valid, 4'b0001 << (k / 4)); end
      total++; if (chan_data(k / 4) !== 8'(k)) begin bad++; $display("FAIL rr_data word=%0d got=%h exp=%h", k, chan_data(k / 4), 8'(k)); end
    end
    in_valid = 1'b0;
    #1;
    total++; if (select_lines !== 2'd0) begin bad++; $display("FAIL rr_wrap got=%0d exp=0", select_lines); end
    @(posedge clk); #1;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL rr_drain got=%b exp=0000", out_valid); end
  endtask

  task automatic test_backpressure();
    send_words(4, 8'h20);              // ptr -> 1
    out_ready = 4'b1101;
    in_valid = 1'b1; in_data = 8'hA5;
    #1;
    total++; if (select_lines !== 2'd1) begin bad++; $display("FAIL bp_sel got=%0d exp=1", select_lines); end
    @(posedge clk); #1;
    total++; if (out_1 !== 8'hA5 || out_valid[1] !== 1'b1) begin bad++; $display("FAIL bp_load got=%h/%b exp=a5/1", out_1, out_valid[1]); end
    in_data = 8'h5A;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    total++; if (out_1 !== 8'hA5 || in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold got=%h/%b exp=a5/0", out_1, in_ready); end
    out_ready = 4'b1111;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    total++; if (out_1 !== 8'h5A || out_valid !== 4'b0010) begin bad++; $display("FAIL bp_reload got=%h/%b exp=5a/0010", out_1, out_valid); end
    in_valid = 1'b0;
    send_words(2, 8'h30);              // finish burst on ch1, ptr -> 2
    #1;
    total++; if (select_lines !== 2'd2) begin bad++; $display("FAIL bp_advance got=%0d exp=2", select_lines); end
    @(posedge clk); #1;
  endtask

  task automatic test_independent_drain();
    out_ready = 4'b1110; mode = 1'b1; fixed_sel = 2'd0;
    send_words(1, 8'h77);
    mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 4'b0001 || out_0 !== 8'h77) begin bad++; $display("FAIL drain_held got=%b/%h exp=0001/77", out_valid, out_0); end
    out_ready = 4'b1111;
    @(posedge clk); #1;
    out_ready = 4'b1110;
    total++; if (out_valid !== 4'b0000) begin bad++; $display("FAIL drain_clear got=%b exp=0000", out_valid); end
    total++; if (select_lines !== 2'd2) begin bad++; $display("FAIL drain_ptr got=%0d exp=2", select_lines); end
    out_ready = 4'b1111;
  endtask

  task automatic test_fixed_mode();
    send_words(4, 8'h40);              // ch2 -> ptr 3
    send_words(4, 8'h44);              // ch3 -> ptr 0
    send_words(4, 8'h48);              // ch0 -> ptr 1
    send_words(2, 8'h4C);              // ch1, cnt = 2
    #1;
    total++; if (select_lines !== 2'd1) begin bad++; $display("FAIL fx_pre_sel got=%0d exp=1", select_lines); end
    mode = 1'b1; fixed_sel = 2'd3;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_data = 8'hB0 + 8'(k);
      #1;
      total++; if (select_lines !== 2'd3) begin bad++; $display("FAIL fx_sel word=%0d got=%0d exp=3", k, select_lines); end
      @(posedge clk); #1;
      total++; if (out_3 !== 8'hB0 + 8'(k) || out_valid !== 4'b1000) begin bad++; $display("FAIL fx_data word=%0d got=%h/%b exp=%h/1000", k, out_3, out_valid, 8'hB0 + 8'(k)); end
    end
    in_valid = 1'b0; mode = 1'b0;
    #1;
    total++; if (select_lines !== 2'd1) begin bad++; $display("FAIL fx_resume got=%0d exp=1", select_lines); end
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'hC0 + 8'(k);
      #1;
      total++; if (select_lines !== 2'd1) begin bad++; $display("FAIL fx_burst word=%0d got=%0d exp=1", k, select_lines); end
      @(posedge clk); #1;
      total++; if (out_1 !== 8'hC0 + 8'(k)) begin bad++; $display("FAIL fx_burst_data word=%0d got=%h exp=%h", k, out_1, 8'hC0 + 8'(k)); end
    end
    in_valid = 1'b0;
    #1;
    total++; if (select_lines !== 2'd2) begin bad++; $display("FAIL fx_advance got=%0d exp=2", select_lines); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_burst();
    out_ready = 4'b1011;
    send_words(1, 8'h99);              // ch2 held, cnt = 1
    #1;
    total++; if (out_valid !== 4'b0100 || select_lines !== 2'd2) begin bad++; $display("FAIL mid_pre got=%b/%0d exp=0100/2", out_valid, select_lines); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 4'b0000 || out_2 !== 8'h00) begin bad++; $display("FAIL mid_async got=%b/%h exp=0000/00", out_valid, out_2); end
    total++; if (select_lines !== 2'd0) begin bad++; $display("FAIL mid_sel got=%0d exp=0", select_lines); end
    rst = 1'b0; out_ready = 4'b1111;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_data = 8'hD0 + 8'(k);
      @(posedge clk); #1;
      total++; if (out_0 !== 8'hD0 + 8'(k) || out_valid !== 4'b0001) begin bad++; $display("FAIL mid_next word=%0d got=%h/%b exp=%h/0001", k, out_0, out_valid, 8'hD0 + 8'(k)); end
    end
    in_valid = 1'b0;
    #1;
    total++; if (select_lines !== 2'd1) begin bad++; $display("FAIL mid_full_burst got=%0d exp=1", select_lines); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_independent_drain();
    test_fixed_mode();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
